// File: rtl/riscv_pkg.sv
// Shared encodings for the execute stage: ALU ops, forwarding selects, branch funct3
// codes and the EX/MEM pipeline register layout.
package riscv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        result_src;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic [31:0] write_data;
    logic [31:0] alu_result;
  } ex_mem_t;

  // Select 11 is unused by the hazard unit and falls back to the register-file value.
  function automatic logic [31:0] fwd_sel(input logic [1:0]  sel,
                                          input logic [31:0] rf_val,
                                          input logic [31:0] wb_val,
                                          input logic [31:0] mem_val);
    logic [31:0] val;
    val = rf_val;
    case (sel)
      FWD_WB:  val = wb_val;
      FWD_MEM: val = mem_val;
      default: val = rf_val;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/execute_cycle_if.sv
// Execute-stage signal bundle: decode-side inputs, branch outputs and EX/MEM outputs.
interface execute_cycle_if;

  logic        RegWriteE;
  logic        MemWriteE;
  logic        ALUSrcE;
  logic        BranchE;
  logic        ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [2:0]  funct3_E;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] Imm_Ext_E;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [31:0] ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E;
  logic [1:0]  ForwardB_E;

  logic        PCSrcE;
  logic [31:0] PCTargetE;

  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M;
  logic [31:0] WriteDataM;
  logic [31:0] ALU_ResultM;

  modport master (
    output RegWriteE, MemWriteE, ALUSrcE, BranchE, ResultSrcE, ALUControlE, funct3_E,
    output RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, RD_E, ForwardA_E, ForwardB_E,
    input  PCSrcE, PCTargetE,
    input  RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM
  );

  modport slave (
    input  RegWriteE, MemWriteE, ALUSrcE, BranchE, ResultSrcE, ALUControlE, funct3_E,
    input  RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, RD_E, ForwardA_E, ForwardB_E,
    output PCSrcE, PCTargetE,
    output RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM
  );

endinterface

// File: rtl/alu.sv
// 32-bit integer ALU for the execute stage: add/sub/and/or/slt plus a zero flag.
module alu
  import riscv_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  alu_control_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  logic slt_bit;

  assign slt_bit = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o = '0;
    case (alu_control_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {31'b0, slt_bit};
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 32'h0);

endmodule

// File: rtl/execute_cycle.sv
// RISC-V execute stage: operand forwarding, ALU, branch resolution and EX/MEM register.
// Define EX_BRANCH_FULL_EN to decode BEQ/BNE/BLT/BGE; otherwise only BEQ is supported.
module execute_cycle
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  execute_cycle_if.slave  ex
);

  ex_mem_t ex_mem_d, ex_mem_q;

  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        zero;
  logic        taken;

  // MEM forwarding reads the live register so dependent ops issue back to back.
  assign src_a = fwd_sel(ex.ForwardA_E, ex.RD1_E, ex.ResultW, ex_mem_q.alu_result);
  assign fwd_b = fwd_sel(ex.ForwardB_E, ex.RD2_E, ex.ResultW, ex_mem_q.alu_result);
  assign src_b = ex.ALUSrcE ? ex.Imm_Ext_E : fwd_b;

  alu u_alu (
    .a_i           (src_a),
    .b_i           (src_b),
    .alu_control_i (ex.ALUControlE),
    .result_o      (alu_result),
    .zero_o        (zero)
  );

`ifdef EX_BRANCH_FULL_EN
  logic lt_signed;

  assign lt_signed = $signed(src_a) < $signed(src_b);

  always_comb begin
    taken = 1'b0;
    case (ex.funct3_E)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = lt_signed;
      F3_BGE:  taken = ~lt_signed;
      default: taken = 1'b0;
    endcase
  end
`else
  logic unused_funct3;

  assign unused_funct3 = ^ex.funct3_E;

  always_comb begin
    taken = zero;
  end
`endif

  assign ex.PCSrcE    = ex.BranchE & taken;
  assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.reg_write  = ex.RegWriteE;
    ex_mem_d.mem_write  = ex.MemWriteE;
    ex_mem_d.result_src = ex.ResultSrcE;
    ex_mem_d.rd         = ex.RD_E;
    ex_mem_d.pc_plus4   = ex.PCPlus4E;
    ex_mem_d.write_data = fwd_b;
    ex_mem_d.alu_result = alu_result;
  end

  // Reset loads an all-zero bubble, dropping whatever was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign ex.RegWriteM   = ex_mem_q.reg_write;
  assign ex.MemWriteM   = ex_mem_q.mem_write;
  assign ex.ResultSrcM  = ex_mem_q.result_src;
  assign ex.RD_M        = ex_mem_q.rd;
  assign ex.PCPlus4M    = ex_mem_q.pc_plus4;
  assign ex.WriteDataM  = ex_mem_q.write_data;
  assign ex.ALU_ResultM = ex_mem_q.alu_result;

endmodule
